// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryptor, one round per clock, fed by an externally expanded key
module aes_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [0:127]           in_data,
    input  logic [0:128*(Nr+1)-1]  w,
    output logic                   busy,
    output logic                   valid,
    output logic [0:127]           out_data
);
    localparam int RW = $clog2(Nr + 1);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Nk only has to agree with Nr; catch mismatched pairings at elaboration.
    if (Nr != Nk + 6) begin : g_bad_params
        $error("aes_cipher_iter: Nr must equal Nk+6");
    end

    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e          fsm_q;
    logic [0:127]  state_q;
    logic [RW-1:0] rnd_q;
    logic [0:127]  sr_d, rk_d, state_d, final_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes fused with ShiftRows: row r of column c comes from column c+r.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*c+8*r +: 8] = sbox(s[32*((c+r)%4)+8*r +: 8]);
        return o;
    endfunction

    function automatic logic [0:127] mix(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    assign rk_d    = w[128*rnd_q +: 128];
    assign sr_d    = sub_shift(state_q);
    assign state_d = mix(sr_d) ^ rk_d;
    assign final_d = sr_d ^ rk_d;

    // Accept a block in IDLE, run middle rounds, then publish the final round with a valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            rnd_q    <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            out_data <= '0;
        end else begin
            valid <= 1'b0;
            if (fsm_q == IDLE) begin
                if (start) begin
                    state_q <= in_data ^ w[0:127];
                    rnd_q   <= RW'(1);
                    busy    <= 1'b1;
                    fsm_q   <= RUN;
                end
            end else if (rnd_q == RW'(Nr)) begin
                out_data <= final_d;
                valid    <= 1'b1;
                busy     <= 1'b0;
                fsm_q    <= IDLE;
            end else begin
                state_q <= state_d;
                rnd_q   <= rnd_q + RW'(1);
            end
        end
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: directed FIPS-197 vectors against AES-128 and AES-256 instances
module tb_aes_cipher_iter;
    localparam logic [0:2047] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:127] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start128, start256, busy128, busy256, valid128, valid256;
    logic [0:127]  in128, in256, out128, out256;
    logic [0:1407] w128;
    logic [0:1919] w256, ex_b, ex_1, ex_3;
    int            checks = 0;
    int            errors = 0;
    int            lat, nv;
    logic          held, b1;

    always #5 clk = ~clk;

    aes_cipher_iter #(.Nk(4), .Nr(10)) u128 (
        .clk(clk), .rst_n(rst_n), .start(start128), .in_data(in128), .w(w128),
        .busy(busy128), .valid(valid128), .out_data(out128)
    );

    aes_cipher_iter #(.Nk(8), .Nr(14)) u256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .in_data(in256), .w(w256),
        .busy(busy256), .valid(valid256), .out_data(out256)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SB[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk, input int nr);
        logic [31:0]   wd [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] res;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) wd[i] = key[32*i +: 32];
            else begin
                t = wd[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                wd[i] = wd[i-nk] ^ t;
            end
            res[32*i +: 32] = wd[i];
        end
        return res;
    endfunction

    task automatic go128(input logic [0:127] pt, input logic [0:1407] kw, input int ig1, input int ig2,
                         output int l, output logic h, output logic bz);
        logic [0:127] o0;
        o0 = out128;
        h  = 1'b1;
        w128 = kw;
        in128 = pt;
        start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        bz = busy128;
        l = 1;
        while (!valid128 && l < 40) begin
            if (out128 !== o0) h = 1'b0;
            start128 = (l == ig1 || l == ig2);
            if (start128) in128 = ~pt;
            @(negedge clk);
            l++;
        end
        start128 = 1'b0;
    endtask

    task automatic go256(input logic [0:127] pt, input logic [0:1919] kw, output int l);
        w256 = kw;
        in256 = pt;
        start256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0;
        l = 1;
        while (!valid256 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic count_valid(input int k, output int n);
        n = 0;
        repeat (k) begin
            @(negedge clk);
            if (valid128) n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start128 = 1'b0;
        start256 = 1'b0;
        in128 = '0;
        in256 = '0;
        w128 = '0;
        w256 = '0;
        ex_b = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        ex_1 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        ex_3 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        repeat (2) @(negedge clk);
        check("rst_busy128", busy128, 0);
        check("rst_valid128", valid128, 0);
        check("rst_out128", out128, 0);
        check("rst_busy256", busy256, 0);
        check("rst_valid256", valid256, 0);
        check("rst_out256", out256, 0);
        rst_n = 1'b1;
        @(negedge clk);

        go128(PT_B, ex_b[0:1407], -1, -1, lat, held, b1);
        check("appb_lat", lat, 11);
        check("appb_out", out128, CT_B);
        check("appb_busy", b1, 1);

        go128(PT_C, ex_1[0:1407], -1, -1, lat, held, b1);
        check("b2b_lat", lat, 11);
        check("b2b_out", out128, CT_1);
        check("b2b_hold", held, 1);

        @(negedge clk);
        go128(PT_B, ex_b[0:1407], 3, 7, lat, held, b1);
        check("ign_lat", lat, 11);
        check("ign_out", out128, CT_B);
        check("ign_hold", held, 1);
        count_valid(20, nv);
        check("ign_nvalid", nv, 0);

        w128 = ex_1[0:1407];
        in128 = PT_C;
        start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy128, 0);
        check("midrst_valid", valid128, 0);
        check("midrst_out", out128, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_valid(20, nv);
        check("midrst_nvalid", nv, 0);
        go128(PT_C, ex_1[0:1407], -1, -1, lat, held, b1);
        check("fresh_lat", lat, 11);
        check("fresh_out", out128, CT_1);

        go256(PT_C, ex_3, lat);
        check("c3_lat", lat, 15);
        check("c3_out", out256, CT_3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES encryption datapath that sits directly downstream of the key-expansion block. It consumes the full expanded-key bus `w` (Nr+1 round keys) and a 128-bit plaintext block, and executes one cipher round per clock. It returns the ciphertext with a single-cycle valid pulse. The block is parameterised identically to key expansion, so AES-128/192/256 instances pair one-to-one with it.

## Interface
- `Nk`, 4, key length in 32-bit words (4/6/8); informational, must match the paired key expansion.
- `Nr`, 10, number of rounds (10/12/14); sets the round-key bus width and the round count.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to encrypt `in_data`; sampled only when `busy`=0.
- `in_data`  in  [0:127]  plaintext; bit 0 is the MSB; byte k = bits [8k:8k+7]; column c = bytes 4c..4c+3.
- `w`  in  [0:128*(Nr+1)-1]  expanded key; round key r = `w[128r +: 128]`.
- `busy`  out  1  high while rounds are in progress.
- `valid`  out  1  one-cycle pulse: `out_data` holds a new ciphertext.
- `out_data`  out  [0:127]  ciphertext; same byte ordering as `in_data`.

## Operation
- FSM has two states: IDLE and RUN. Registers:
  - 128-bit `state`
  - round counter `rnd`, width ceil(log2(Nr+1))
  - `out_data`
  - `valid`
- IDLE with `start`=1:
  - `state` <= `in_data` ^ roundkey 0
  - `rnd` <= 1
  - FSM -> RUN
  - `busy` <= 1
- RUN with `rnd` < Nr:
  - `state` <= MixColumns(ShiftRows(SubBytes(`state`))) ^ roundkey `rnd`
  - `rnd` <= `rnd`+1
- RUN with `rnd` == Nr (final round, no MixColumns):
  - `out_data` <= ShiftRows(SubBytes(`state`)) ^ roundkey Nr
  - `valid` <= 1
  - `busy` <= 0
  - FSM -> IDLE
- SubBytes uses the codebase's standard forward S-box.
- ShiftRows: row r (byte r of each column) rotates left by r columns.
- MixColumns uses the standard {02,03,01,01} circulant over GF(2^8), with reduction polynomial 0x11b.
- All XOR and GF arithmetic is on 8-bit lanes with no carries; `rnd` never exceeds Nr.
- `start` while `busy`=1 is ignored: no queueing, no error flag.
- `w` must be held stable from the `start` cycle through the `valid` cycle. The block does not latch `w`.
- `in_data` is sampled only in the accepting cycle and may change afterwards.

## Timing
- Reset values: `busy`=0, `valid`=0, `out_data`=0, `state`=0, `rnd`=0, FSM=IDLE.
- Reset asserted mid-operation aborts at once: no `valid` is produced and the block returns to IDLE.
- `start` is accepted on edge T0, which makes `busy`=1 after T0.
- `valid`=1 for exactly one cycle after edge T0+Nr, i.e. latency Nr+1 cycles: 11 for AES-128, 13 for AES-192, 15 for AES-256.
- `busy` deasserts on the same edge that raises `valid`.
- Back-to-back operation: `start` asserted in the `valid` cycle is accepted. The throughput is one block per Nr+1 cycles.
- `out_data` holds its value until the next completion; it does not change when a new `start` is accepted.
- `valid` never asserts twice for a single accepted `start`.

## Test plan
- FIPS-197 App. B, Nk=4/Nr=10:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c expanded, pt 3243f6a8885a308d313198a2e0370734, `start` pulse.
  - Required: `valid` exactly 11 cycles later with `out_data`=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1, Nk=4:
  - Stimulus: key 000102…0f, pt 00112233445566778899aabbccddeeff.
  - Required: `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back:
  - Stimulus: assert C.1 `start` in the `valid` cycle of App. B.
  - Required: the second `valid` arrives exactly 11 cycles later, and `out_data` holds 3925…0b32 until then.
- Ignored start:
  - Stimulus: pulse `start` with different `in_data` at cycles 3 and 7 of a run.
  - Required: result unchanged, and only one `valid` is produced.
- Reset mid-run:
  - Stimulus: drive `rst_n` low at cycle 5.
  - Required: `busy`, `valid` and `out_data` read 0 at once, and no `valid` follows. A fresh `start` then completes correctly.
- Nk=8/Nr=14 instance, FIPS-197 C.3:
  - Stimulus: key 00…1f, pt 00112233…eeff.
  - Required: `out_data`=8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
